// File: rtl/fifo_stream_pkg.sv
// Shared sizing constants and index helper for the FIFO read-side stream reader.
package fifo_stream_pkg;
  localparam int BUF_DEPTH   = 3;
  localparam int CNT_W       = 2;
  localparam int FRAME_CNT_W = 16;

  function automatic logic [CNT_W-1:0] idx_inc(input logic [CNT_W-1:0] idx);
    return (idx == CNT_W'(BUF_DEPTH - 1)) ? '0 : idx + CNT_W'(1);
  endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [CNT_W-1:0]      head;
  logic [CNT_W-1:0]      tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= idx_inc(tail);
      end
      if (pop) head <= idx_inc(head);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the dual-clock FIFO read side and presents the words as a framed valid/ready stream.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    pending;
  logic [BEAT_W-1:0] beat;
  logic              pop;

  // Issue depends only on registered state and fifo_empty, so a word popped
  // now always has a free slot when it lands next cycle.
  assign pending    = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en = !rd_rst && !fifo_empty && (pending < DEPTH_LIM);

  // Stream handshake: a beat transfers on a cycle with out_valid && out_ready;
  // out_valid never waits on out_ready, and out_data/out_last hold until that transfer.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (beat == LAST_BEAT);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight    <= 1'b0;
      beat        <= '0;
      frame_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        if (beat == LAST_BEAT) begin
          beat        <= '0;
          frame_count <= frame_count + FRAME_CNT_W'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .count     (count),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomised checks of fifo_stream_reader against a FIFO model.
module tb_fifo_stream_reader;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rd_rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [15:0]   frame_count;

  logic          empty1;
  logic          rd_en1;
  logic [DW-1:0] rd_data1;
  logic          valid1;
  logic          ready1;
  logic [DW-1:0] data1;
  logic          last1;
  logic [15:0]   frames1;
  logic [DW-1:0] src1;

  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr = '0;
  logic          force_empty;

  int            checks;
  int            errors;
  logic [DW-1:0] exp_q[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_count(frame_count)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
    .fifo_rd_data(rd_data1), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_last(last1), .frame_count(frames1)
  );

  // FIFO model: one-cycle read latency, contents written by the driver tasks.
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  // Endless counting source for the single-beat-frame instance.
  assign empty1 = 1'b0;
  always @(posedge clk) begin
    if (rd_rst) begin
      src1     <= 16'd1;
      rd_data1 <= '0;
    end else if (rd_en1) begin
      rd_data1 <= src1;
      src1     <= src1 + 16'd1;
    end
  end

  task automatic fill(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic test_reset();
    int got;
    rd_rst = 1'b1; out_ready = 1'b0; force_empty = 1'b0; ready1 = 1'b0; wr_ptr = '0;
    for (int i = 0; i < 4; i++) fill(DW'(16'hA001 + i));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last); end
      checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", frame_count); end
    end
    @(negedge clk); rd_rst = 1'b0; #2;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_rd_en got=%b exp=1", fifo_rd_en); end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk); #2;
      if (out_valid) begin
        checks++; if (out_data !== DW'(16'hA001 + got)) begin errors++; $display("FAIL reset_drain_data got=%h exp=%h", out_data, DW'(16'hA001 + got)); end
        checks++; if (out_last !== (got == 3)) begin errors++; $display("FAIL reset_drain_last got=%b exp=%b", out_last, (got == 3)); end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL reset_drain_count got=%0d exp=4", got); end
    @(negedge clk); #2;
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL reset_drain_frames got=%0d exp=1", frame_count); end
  endtask

  task automatic test_streaming();
    logic exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) for (int i = 1; i <= 8; i++) fill(DW'(i));
      #2;
      if (k == 0) begin
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stream_first_pop got=%b exp=1", fifo_rd_en); end
      end
      exp_v = (k >= 2) && (k <= 9);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== DW'(k - 1)) begin errors++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, DW'(k - 1)); end
        checks++; if (out_last !== (k == 5 || k == 9)) begin errors++; $display("FAIL stream_last k=%0d got=%b exp=%b", k, out_last, (k == 5 || k == 9)); end
      end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL stream_frames got=%0d exp=3", frame_count); end
  endtask

  task automatic test_backpressure();
    int pops;
    int got;
    out_ready = 1'b0;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) for (int i = 0; i < 8; i++) fill(DW'(16'h0101 + i));
      #2;
      if (fifo_rd_en) pops++;
      if (k >= 3) begin
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en k=%0d got=%b exp=0", k, fifo_rd_en); end
      end
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0101) begin errors++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/0101", k, out_valid, out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bp_last k=%0d got=%b exp=0", k, out_last); end
      end
    end
    checks++; if (pops != 3) begin errors++; $display("FAIL bp_pops got=%0d exp=3", pops); end
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk); out_ready = 1'b1; #2;
      if (out_valid) begin
        checks++; if (out_data !== DW'(16'h0101 + got)) begin errors++; $display("FAIL bp_data got=%h exp=%h", out_data, DW'(16'h0101 + got)); end
        checks++; if (out_last !== (got % 4 == 3)) begin errors++; $display("FAIL bp_drain_last got=%b exp=%b", out_last, (got % 4 == 3)); end
        got++;
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got); end
    @(negedge clk); #2;
    checks++; if (frame_count !== 16'd5 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%0d/%b exp=5/0", frame_count, out_valid); end
  endtask

  task automatic test_empty_mid();
    int got;
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin fill(16'h0201); fill(16'h0202); end
      #2;
      if (out_valid) begin
        checks++; if (out_data !== DW'(16'h0201 + got)) begin errors++; $display("FAIL em_data got=%h exp=%h", out_data, DW'(16'h0201 + got)); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL em_last_early got=%b exp=0", out_last); end
        got++;
      end
    end
    checks++; if (got != 2) begin errors++; $display("FAIL em_count got=%0d exp=2", got); end
    checks++; if (dut.beat !== 2'd2) begin errors++; $display("FAIL em_beat got=%0d exp=2", dut.beat); end
    checks++; if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL em_idle got=%b/%b exp=0/0", out_valid, fifo_rd_en); end
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL em_frames_open got=%0d exp=5", frame_count); end
    for (int c = 0; c < 10 && got < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin fill(16'h0203); fill(16'h0204); end
      #2;
      if (out_valid) begin
        checks++; if (out_data !== DW'(16'h0201 + got)) begin errors++; $display("FAIL em_refill_data got=%h exp=%h", out_data, DW'(16'h0201 + got)); end
        checks++; if (out_last !== (got == 3)) begin errors++; $display("FAIL em_refill_last got=%b exp=%b", out_last, (got == 3)); end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL em_refill_count got=%0d exp=4", got); end
    @(negedge clk); #2;
    checks++; if (frame_count !== 16'd6) begin errors++; $display("FAIL em_frames got=%0d exp=6", frame_count); end
  endtask

  task automatic test_random();
    int            m_beat;
    int            m_frames;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] w;
    m_beat = 0; m_frames = 6; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 10100; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        out_ready   = ($urandom_range(0, 3) != 0);
        force_empty = ($urandom_range(0, 4) == 0);
        if (8'(wr_ptr - rd_ptr) < 8'd6 && $urandom_range(0, 1) == 1) begin
          w = DW'($urandom);
          fill(w);
          exp_q.push_back(w);
        end
      end else begin
        out_ready   = 1'b1;
        force_empty = 1'b0;
      end
      #2;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin errors++; $display("FAIL rand_stall cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid, out_data, out_last, prev_data, prev_last); end
      end
      checks++; if (int'(dut.u_buf.count) + int'(dut.inflight) > 3) begin errors++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp<=3", cyc, int'(dut.u_buf.count) + int'(dut.inflight)); end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_extra cyc=%0d got=%h exp=none", cyc, out_data); end
        else if (out_data !== exp_q[0]) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_q[0]); end
        checks++; if (out_last !== (m_beat == 3)) begin errors++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", cyc, out_last, (m_beat == 3)); end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_beat = (m_beat == 3) ? 0 : m_beat + 1;
          if (m_beat == 0) m_frames++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got=%0d exp=0 words left", exp_q.size()); end
    checks++; if (frame_count !== 16'(m_frames)) begin errors++; $display("FAIL rand_frames got=%0d exp=%0d", frame_count, 16'(m_frames)); end
  endtask

  task automatic test_reset_mid();
    int got;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) for (int i = 0; i < 8; i++) fill(DW'(16'hC001 + i));
      #2;
    end
    checks++; if (dut.u_buf.count !== 2'd2 || dut.inflight !== 1'b1) begin errors++; $display("FAIL rm_setup got=%0d/%b exp=2/1", dut.u_buf.count, dut.inflight); end
    @(negedge clk); rd_rst = 1'b1; #2;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rm_rd_en got=%b exp=0", fifo_rd_en); end
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rm_flags got=%b/%b exp=0/0", out_valid, out_last); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rm_data got=%h exp=0000", out_data); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL rm_frames got=%0d exp=0", frame_count); end
    @(negedge clk); rd_rst = 1'b0; out_ready = 1'b1; #2;
    checks++; if (out_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rm_release got=%b/%b exp=0/1", out_valid, fifo_rd_en); end
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk); #2;
      if (out_valid) begin
        checks++; if (out_data !== DW'(16'hC004 + got)) begin errors++; $display("FAIL rm_drain_data got=%h exp=%h", out_data, DW'(16'hC004 + got)); end
        checks++; if (out_last !== (got == 3)) begin errors++; $display("FAIL rm_drain_last got=%b exp=%b", out_last, (got == 3)); end
        got++;
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL rm_drain_count got=%0d exp=5", got); end
    @(negedge clk); #2;
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rm_frames_after got=%0d exp=1", frame_count); end
  endtask

  task automatic test_burst1();
    logic [DW-1:0] nxt;
    int            beats;
    nxt = 16'd1; beats = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk); ready1 = ($urandom_range(0, 1) == 1); #2;
      if (valid1) begin
        checks++; if (data1 !== nxt) begin errors++; $display("FAIL b1_data got=%h exp=%h", data1, nxt); end
        checks++; if (last1 !== 1'b1) begin errors++; $display("FAIL b1_last got=%b exp=1", last1); end
        if (ready1) begin nxt = nxt + 16'd1; beats++; end
      end
    end
    @(negedge clk); ready1 = 1'b0; #2;
    checks++; if (frames1 !== 16'(beats)) begin errors++; $display("FAIL b1_frames got=%0d exp=%0d", frames1, beats); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_mid();
    test_random();
    test_reset_mid();
    test_burst1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
